// File: rtl/conv_window_feeder.sv
// Streaming front end for the 3x3 MAC: fetches packed 3-row columns of image and weight data,
// slides a 3x3 window across them and hands one window per cycle downstream under stall control.
module conv_window_feeder #(
    parameter int ADDR_W = 17,
    parameter int IMG_W  = 8,
    parameter int WGT_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_stall,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       img_rdata,
    input  logic [23:0]       wgt_rdata,
    output logic              o_valid,
    output logic [IMG_W-1:0]  o_im1,
    output logic [IMG_W-1:0]  o_im2,
    output logic [IMG_W-1:0]  o_im3,
    output logic [IMG_W-1:0]  o_im4,
    output logic [IMG_W-1:0]  o_im5,
    output logic [IMG_W-1:0]  o_im6,
    output logic [IMG_W-1:0]  o_im7,
    output logic [IMG_W-1:0]  o_im8,
    output logic [IMG_W-1:0]  o_im9,
    output logic [WGT_W-1:0]  o_ker1,
    output logic [WGT_W-1:0]  o_ker2,
    output logic [WGT_W-1:0]  o_ker3,
    output logic [WGT_W-1:0]  o_ker4,
    output logic [WGT_W-1:0]  o_ker5,
    output logic [WGT_W-1:0]  o_ker6,
    output logic [WGT_W-1:0]  o_ker7,
    output logic [WGT_W-1:0]  o_ker8,
    output logic [WGT_W-1:0]  o_ker9,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] len, rd_cnt, col_cnt, col_next;
    logic              pend, skid_vld, shift_en, last_accept;
    logic [IMG_W-1:0]  skid_img [3];
    logic [WGT_W-1:0]  skid_wgt [3];
    logic [IMG_W-1:0]  new_img  [3];
    logic [WGT_W-1:0]  new_wgt  [3];
    logic [IMG_W-1:0]  win_im   [9];
    logic [WGT_W-1:0]  win_ker  [9];
    logic              unused_rdata;

    assign unused_rdata = ^{wgt_rdata[23:16+WGT_W], wgt_rdata[15:8+WGT_W], wgt_rdata[7:WGT_W]};

    // A column enters the window either from the skid (older, drains first) or straight off the bus.
    assign shift_en    = !i_stall && (skid_vld || pend);
    assign col_next    = col_cnt + ADDR_W'(1);
    assign last_accept = o_valid && !i_stall && (col_cnt == len);

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            new_img[r] = skid_vld ? skid_img[r] : img_rdata[8*r +: IMG_W];
            new_wgt[r] = skid_vld ? skid_wgt[r] : wgt_rdata[8*r +: WGT_W];
        end
    end

    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                if (i_start) next_state = (i_len >= ADDR_W'(3)) ? FETCH : DONE;
            end
            FETCH: begin
                mem_addr = rd_cnt;
                if (!i_stall && !skid_vld) begin
                    mem_rd = 1'b1;
                    if (rd_cnt == len - ADDR_W'(1)) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (last_accept) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            len      <= '0;
            rd_cnt   <= '0;
            col_cnt  <= '0;
            pend     <= 1'b0;
            skid_vld <= 1'b0;
            o_valid  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                skid_img[r] <= '0;
                skid_wgt[r] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                win_im[i]  <= '0;
                win_ker[i] <= '0;
            end
        end else begin
            state <= next_state;
            pend  <= mem_rd;
            if (state == IDLE && i_start) begin
                len     <= i_len;
                rd_cnt  <= '0;
                col_cnt <= '0;
            end
            if (mem_rd) rd_cnt <= rd_cnt + ADDR_W'(1);
            // While stalled everything freezes except catching the word already on its way back.
            if (i_stall) begin
                if (pend) begin
                    skid_vld <= 1'b1;
                    for (int r = 0; r < 3; r++) begin
                        skid_img[r] <= img_rdata[8*r +: IMG_W];
                        skid_wgt[r] <= wgt_rdata[8*r +: WGT_W];
                    end
                end
            end else begin
                skid_vld <= 1'b0;
                o_valid  <= shift_en && (col_next >= ADDR_W'(3));
                if (shift_en) begin
                    col_cnt <= col_next;
                    for (int r = 0; r < 3; r++) begin
                        win_im[3*r]    <= win_im[3*r+1];
                        win_im[3*r+1]  <= win_im[3*r+2];
                        win_im[3*r+2]  <= new_img[r];
                        win_ker[3*r]   <= win_ker[3*r+1];
                        win_ker[3*r+1] <= win_ker[3*r+2];
                        win_ker[3*r+2] <= new_wgt[r];
                    end
                end
            end
        end
    end

    assign o_im1  = win_im[0];
    assign o_im2  = win_im[1];
    assign o_im3  = win_im[2];
    assign o_im4  = win_im[3];
    assign o_im5  = win_im[4];
    assign o_im6  = win_im[5];
    assign o_im7  = win_im[6];
    assign o_im8  = win_im[7];
    assign o_im9  = win_im[8];
    assign o_ker1 = win_ker[0];
    assign o_ker2 = win_ker[1];
    assign o_ker3 = win_ker[2];
    assign o_ker4 = win_ker[3];
    assign o_ker5 = win_ker[4];
    assign o_ker6 = win_ker[5];
    assign o_ker7 = win_ker[6];
    assign o_ker8 = win_ker[7];
    assign o_ker9 = win_ker[8];
    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: memory responder, stall/start/reset driver and a window-list model
// that states which 3x3 windows must appear, in which order, and when the job must finish.
module tb_conv_window_feeder;

    localparam int ADDR_W = 17;
    localparam int MAXN   = 64;

    logic              clk = 1'b0;
    logic              rstn, i_start, i_stall;
    logic [ADDR_W-1:0] i_len;
    logic              mem_rd, o_valid, o_busy, o_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       img_rdata = '0, wgt_rdata = '0;
    logic [7:0]        o_im1, o_im2, o_im3, o_im4, o_im5, o_im6, o_im7, o_im8, o_im9;
    logic [3:0]        o_ker1, o_ker2, o_ker3, o_ker4, o_ker5, o_ker6, o_ker7, o_ker8, o_ker9;

    logic [23:0] img_mem [MAXN];
    logic [23:0] wgt_mem [MAXN];
    logic        ret_valid = 1'b0;

    int  cyc = 0, total = 0, bad = 0;
    int  start_cyc = 0, nlen = 0, nwin = 0, idx = 0, rd_exp = 0, last_acc = 0;
    bit  job_active = 0, done_seen = 0, nostall = 0;
    logic [71:0]  got_im, first_im;
    logic [35:0]  got_ker, first_ker;
    logic [128:0] all_out;

    conv_window_feeder #(.ADDR_W(ADDR_W), .IMG_W(8), .WGT_W(4)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_len(i_len), .i_stall(i_stall),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .img_rdata(img_rdata), .wgt_rdata(wgt_rdata),
        .o_valid(o_valid),
        .o_im1(o_im1), .o_im2(o_im2), .o_im3(o_im3), .o_im4(o_im4), .o_im5(o_im5),
        .o_im6(o_im6), .o_im7(o_im7), .o_im8(o_im8), .o_im9(o_im9),
        .o_ker1(o_ker1), .o_ker2(o_ker2), .o_ker3(o_ker3), .o_ker4(o_ker4), .o_ker5(o_ker5),
        .o_ker6(o_ker6), .o_ker7(o_ker7), .o_ker8(o_ker8), .o_ker9(o_ker9),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign got_im  = {o_im9, o_im8, o_im7, o_im6, o_im5, o_im4, o_im3, o_im2, o_im1};
    assign got_ker = {o_ker9, o_ker8, o_ker7, o_ker6, o_ker5, o_ker4, o_ker3, o_ker2, o_ker1};
    assign all_out = {o_valid, mem_rd, mem_addr, o_busy, o_done, got_im, got_ker};

    // Memory with one cycle of read latency; the bus carries junk whenever no read was issued.
    always @(posedge clk) begin
        ret_valid <= mem_rd;
        if (mem_rd === 1'b1) begin
            img_rdata <= img_mem[mem_addr[5:0]];
            wgt_rdata <= wgt_mem[mem_addr[5:0]];
        end else begin
            img_rdata <= 24'($urandom);
            wgt_rdata <= 24'($urandom);
        end
    end

    task automatic checkOutput(input string name, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Window w covers columns w..w+2; row r of a column is byte r (pixels) or the low nibble of byte r (weights).
    function automatic logic [71:0] expIm(input int w);
        logic [71:0] v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(r*3+c)*8 +: 8] = img_mem[w+c][r*8 +: 8];
        return v;
    endfunction

    function automatic logic [35:0] expKer(input int w);
        logic [35:0] v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(r*3+c)*4 +: 4] = wgt_mem[w+c][r*8 +: 4];
        return v;
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (rstn) begin
            if (job_active && cyc >= start_cyc) begin
                checkOutput("busy", 160'(o_busy), 160'(1));
                if (mem_rd) begin
                    checkOutput("rd_no_stall", 160'(i_stall), 160'(0));
                    checkOutput("rd_addr", 160'(mem_addr), 160'(rd_exp));
                    rd_exp++;
                end
                if (o_valid) begin
                    if (idx < nwin) begin
                        checkOutput("win_im", 160'(got_im), 160'(expIm(idx)));
                        checkOutput("win_ker", 160'(got_ker), 160'(expKer(idx)));
                        if (idx == 0) begin
                            first_im  = got_im;
                            first_ker = got_ker;
                            if (nostall) checkOutput("first_latency", 160'(cyc - start_cyc), 160'(4));
                        end
                    end else begin
                        checkOutput("extra_window", 160'(idx), 160'(nwin - 1));
                    end
                    if (!i_stall) begin
                        idx++;
                        last_acc = cyc;
                    end
                end
                if (o_done) begin
                    checkOutput("done_windows", 160'(idx), 160'(nwin));
                    checkOutput("done_reads", 160'(rd_exp), 160'((nlen >= 3) ? nlen : 0));
                    checkOutput("done_time", 160'(cyc), 160'((nwin > 0) ? last_acc + 1 : start_cyc));
                    job_active = 0;
                    done_seen  = 1;
                end
            end else if (!job_active) begin
                checkOutput("idle_quiet", 160'({o_valid, mem_rd, o_done, o_busy}), 160'(0));
            end
        end
    end

    // mode 0: no stall, 1: random stall, 2: stall over the 2nd window, 3: stall on data return,
    // 4: extra start pulse mid-job, 5: random stall then reset mid-job
    task automatic applyStimulus(input int n, input int mode, input int fill);
        bit aborted = 0;
        int rel;
        for (int k = 0; k < MAXN; k++) begin
            logic [7:0] b = 8'(k);
            case (fill)
                1: begin
                    img_mem[k] = {8'h20 + b, 8'h10 + b, b};
                    wgt_mem[k] = {4'h0, 4'hA, 4'h0, 4'h5, 4'h0, b[3:0]};
                end
                2: begin
                    img_mem[k] = {8'h20 + b, 8'h10 + b, b};
                    wgt_mem[k] = {4'hF, 4'hA, 4'hF, 4'h5, 4'hF, b[3:0]};
                end
                default: begin
                    img_mem[k] = 24'($urandom);
                    wgt_mem[k] = 24'($urandom);
                end
            endcase
        end
        nlen = n; nwin = (n >= 3) ? n - 2 : 0; idx = 0; rd_exp = 0; last_acc = 0;
        done_seen = 0; nostall = (mode == 0); first_im = '0; first_ker = '0;
        @(negedge clk);
        i_len = ADDR_W'(n); i_start = 1; i_stall = 0;
        start_cyc = cyc + 1; job_active = 1;
        for (int t = 0; t < 3000 && !done_seen && !aborted; t++) begin
            @(negedge clk);
            i_start = 0;
            rel = cyc - start_cyc;
            case (mode)
                1, 5: i_stall = ($urandom_range(0, 99) < 30);
                2:    i_stall = (rel >= 5 && rel <= 7);
                3:    i_stall = ret_valid && ($urandom_range(0, 1) == 1);
                default: i_stall = 0;
            endcase
            if (mode == 4 && rel == 6) begin
                i_start = 1;
                i_len   = ADDR_W'(4);
            end
            if (mode == 5 && rel == 9) begin
                rstn = 0; job_active = 0; aborted = 1;
            end
        end
        if (aborted) begin
            @(negedge clk);
            rstn = 1; i_stall = 0;
            #3;
            checkOutput("abort_reset_outputs", 160'(all_out), 160'(0));
            repeat (6) @(negedge clk);
        end else if (!done_seen) begin
            total++; bad++;
            $display("[TB] FAIL job_timeout got=no_done exp=done n=%0d", n);
            job_active = 0;
        end
        i_stall = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstn = 0; i_start = 0; i_len = '0; i_stall = 0;
        repeat (3) @(negedge clk);
        rstn = 1;
        #3;
        checkOutput("reset_outputs", 160'(all_out), 160'(0));

        $display("[TB] basic N=5 with known columns");
        applyStimulus(5, 0, 1);
        checkOutput("t1_first_im", 160'(first_im), 160'(72'h22_21_20_12_11_10_02_01_00));
        checkOutput("t1_first_ker", 160'(first_ker), 160'(36'hAAA555210));

        $display("[TB] stall while second window is up");
        applyStimulus(8, 2, 0);
        $display("[TB] stall on returning read data");
        applyStimulus(7, 3, 0);
        $display("[TB] short and minimum lengths");
        applyStimulus(2, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(3, 0, 0);
        $display("[TB] start pulse during a job");
        applyStimulus(10, 4, 0);
        $display("[TB] reset during a job, then restart");
        applyStimulus(20, 5, 0);
        applyStimulus(6, 0, 0);
        $display("[TB] junk in unused weight bits");
        applyStimulus(6, 0, 2);
        checkOutput("t6_first_im", 160'(first_im), 160'(72'h22_21_20_12_11_10_02_01_00));
        checkOutput("t6_first_ker", 160'(first_ker), 160'(36'hAAA555210));

        $display("[TB] randomized jobs");
        for (int j = 0; j < 10; j++) begin
            int m = $urandom_range(0, 2);
            applyStimulus($urandom_range(3, 40), (m == 2) ? 3 : m, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
